// File: rtl/shiftregister_serializer_pkg.sv
// shiftregister_pkg: shared state type, counter sizing and default width for the serializer.
package shiftregister_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
  localparam int DEFAULT_WIDTH = 4;
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/shiftregister_serializer_load_left.sv
// shiftregister_load_left: WIDTH-bit register with parallel load (priority), left shift and hold.
module shiftregister_load_left #(
  parameter int WIDTH = 4
) (
  input  logic             clockpulse,
  input  logic             clear,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clockpulse or negedge clear)
    if (!clear) q <= '0;
    else if (load) q <= d;
    else if (shift) q <= {q[WIDTH-2:0], 1'b0};
endmodule

// File: rtl/shiftregister_serializer.sv
// shiftregister_serializer: MSB-first parallel-to-serial sender with valid/ready load and back-to-back frames.
// Defining SHIFTREGISTER_SERIALIZER_PARITY_EN appends an even-parity bit to each frame.
module shiftregister_serializer
  import shiftregister_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clockpulse,
  input  logic             clear,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] parallel_input,
  input  logic             shift_enable,
  output logic             serial_output,
  output logic             serial_valid,
  output logic             serial_last
);
  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] sr;
  logic last_data, last_bit, load, shift;
  assign last_data = state == SHIFT && cnt == LAST;
`ifdef SHIFTREGISTER_SERIALIZER_PARITY_EN
  logic par;
  assign last_bit = state == PARITY;
  assign serial_output = state == SHIFT ? sr[WIDTH-1] : state == PARITY && par;
  always_ff @(posedge clockpulse or negedge clear)
    if (!clear) par <= 1'b0;
    else if (load) par <= ^parallel_input;
`else
  assign last_bit = last_data;
  assign serial_output = state == SHIFT && sr[WIDTH-1];
`endif
  assign serial_valid = state != IDLE;
  assign serial_last  = last_bit;
  // Handshake only opens on the final bit-time when it will actually advance, keeping frames gapless.
  assign load_ready   = state == IDLE || (last_bit && shift_enable);
  assign load         = load_valid && load_ready;
  assign shift        = state == SHIFT && shift_enable;
  shiftregister_load_left #(.WIDTH(WIDTH)) u_sr (
    .clockpulse(clockpulse),
    .clear     (clear),
    .load      (load),
    .shift     (shift),
    .d         (parallel_input),
    .q         (sr)
  );
  always_ff @(posedge clockpulse or negedge clear)
    if (!clear) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (load) begin
      state <= SHIFT;
      cnt   <= '0;
    end else if (shift_enable && state != IDLE) begin
      if (last_bit) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
`ifdef SHIFTREGISTER_SERIALIZER_PARITY_EN
        if (last_data) state <= PARITY;
`endif
      end
    end
endmodule

// File: tb/tb_shiftregister_serializer.sv
// tb_shiftregister_serializer: directed scenario tasks for the serializer, optional parity build included.
module tb_shiftregister_serializer;
  localparam int W = 4;
`ifdef SHIFTREGISTER_SERIALIZER_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif
  logic clockpulse = 1'b0, clear = 1'b0, load_valid = 1'b0, shift_enable = 1'b0;
  logic [W-1:0] parallel_input = '0;
  logic load_ready, serial_output, serial_valid, serial_last;
  int n_vec = 0, n_err = 0;

  shiftregister_serializer #(.WIDTH(W)) dut (
    .clockpulse    (clockpulse),
    .clear         (clear),
    .load_valid    (load_valid),
    .load_ready    (load_ready),
    .parallel_input(parallel_input),
    .shift_enable  (shift_enable),
    .serial_output (serial_output),
    .serial_valid  (serial_valid),
    .serial_last   (serial_last)
  );

  always #5 clockpulse = ~clockpulse;

  function automatic logic exp_bit(input logic [W-1:0] w, input int i);
    return i < W ? w[W-1-i] : ^w;
  endfunction

  task automatic tick;
    @(posedge clockpulse);
    #1;
  endtask

  task automatic test_reset;
    clear = 1'b0;
    repeat (2) tick;
    n_vec++; if (serial_output !== 1'b0) begin n_err++; $display("FAIL reset_out got=%b exp=0", serial_output); end
    n_vec++; if (serial_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", serial_valid); end
    n_vec++; if (serial_last !== 1'b0) begin n_err++; $display("FAIL reset_last got=%b exp=0", serial_last); end
    n_vec++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", load_ready); end
    clear = 1'b1;
    tick;
  endtask

  task automatic test_single_frame(input logic [W-1:0] w);
    load_valid = 1'b1; parallel_input = w; shift_enable = 1'b1;
    tick;
    load_valid = 1'b0; parallel_input = '0;
    for (int i = 0; i < FL; i++) begin
      n_vec++; if (serial_output !== exp_bit(w, i)) begin n_err++; $display("FAIL single_bit%0d got=%b exp=%b", i, serial_output, exp_bit(w, i)); end
      n_vec++; if (serial_valid !== 1'b1) begin n_err++; $display("FAIL single_valid%0d got=%b exp=1", i, serial_valid); end
      n_vec++; if (serial_last !== (i == FL - 1)) begin n_err++; $display("FAIL single_last%0d got=%b exp=%b", i, serial_last, i == FL - 1); end
      n_vec++; if (load_ready !== (i == FL - 1)) begin n_err++; $display("FAIL single_ready%0d got=%b exp=%b", i, load_ready, i == FL - 1); end
      tick;
    end
    n_vec++; if (serial_valid !== 1'b0 || serial_output !== 1'b0 || load_ready !== 1'b1)
      begin n_err++; $display("FAIL single_idle got v=%b o=%b r=%b exp v=0 o=0 r=1", serial_valid, serial_output, load_ready); end
  endtask

  task automatic test_back_to_back(input logic [W-1:0] a, input logic [W-1:0] b);
    load_valid = 1'b1; parallel_input = a; shift_enable = 1'b1;
    tick;
    load_valid = 1'b0;
    for (int i = 0; i < 2 * FL; i++) begin
      logic [W-1:0] w;
      int j;
      w = i < FL ? a : b;
      j = i % FL;
      if (i == FL - 1) begin
        load_valid = 1'b1; parallel_input = b;
        n_vec++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready got=%b exp=1", load_ready); end
      end
      n_vec++; if (serial_output !== exp_bit(w, j)) begin n_err++; $display("FAIL b2b_bit%0d got=%b exp=%b", i, serial_output, exp_bit(w, j)); end
      n_vec++; if (serial_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid%0d got=%b exp=1", i, serial_valid); end
      n_vec++; if (serial_last !== (j == FL - 1)) begin n_err++; $display("FAIL b2b_last%0d got=%b exp=%b", i, serial_last, j == FL - 1); end
      tick;
      load_valid = 1'b0;
    end
    n_vec++; if (serial_valid !== 1'b0) begin n_err++; $display("FAIL b2b_idle got=%b exp=0", serial_valid); end
  endtask

  task automatic test_stall(input logic [W-1:0] w);
    load_valid = 1'b1; parallel_input = w; shift_enable = 1'b1;
    tick;
    load_valid = 1'b0;
    for (int i = 0; i < FL; i++) begin
      n_vec++; if (serial_output !== exp_bit(w, i)) begin n_err++; $display("FAIL stall_bit%0d got=%b exp=%b", i, serial_output, exp_bit(w, i)); end
      if (i == 1) begin
        shift_enable = 1'b0;
        load_valid = 1'b1; parallel_input = 4'b0110;
        for (int k = 0; k < 2; k++) begin
          #1;
          n_vec++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready%0d got=%b exp=0", k, load_ready); end
          tick;
          n_vec++; if (serial_output !== exp_bit(w, i) || serial_valid !== 1'b1 || serial_last !== 1'b0)
            begin n_err++; $display("FAIL stall_hold%0d got o=%b v=%b l=%b exp o=%b v=1 l=0", k, serial_output, serial_valid, serial_last, exp_bit(w, i)); end
        end
        shift_enable = 1'b1; load_valid = 1'b0;
      end
      tick;
    end
    n_vec++; if (serial_valid !== 1'b0 || load_ready !== 1'b1) begin n_err++; $display("FAIL stall_idle got v=%b r=%b exp v=0 r=1", serial_valid, load_ready); end
  endtask

  task automatic test_reset_mid_frame(input logic [W-1:0] a, input logic [W-1:0] b);
    load_valid = 1'b1; parallel_input = a; shift_enable = 1'b1;
    tick;
    load_valid = 1'b0;
    repeat (2) tick;
    #2 clear = 1'b0;
    #1;
    n_vec++; if (serial_output !== 1'b0 || serial_valid !== 1'b0 || serial_last !== 1'b0 || load_ready !== 1'b1)
      begin n_err++; $display("FAIL midreset_async got o=%b v=%b l=%b r=%b exp 0 0 0 1", serial_output, serial_valid, serial_last, load_ready); end
    repeat (2) tick;
    #2 clear = 1'b1;
    tick;
    n_vec++; if (serial_valid !== 1'b0) begin n_err++; $display("FAIL midreset_idle got=%b exp=0", serial_valid); end
    load_valid = 1'b1; parallel_input = b;
    tick;
    load_valid = 1'b0;
    for (int i = 0; i < FL; i++) begin
      n_vec++; if (serial_output !== exp_bit(b, i) || serial_valid !== 1'b1)
        begin n_err++; $display("FAIL midreset_bit%0d got o=%b v=%b exp o=%b v=1", i, serial_output, serial_valid, exp_bit(b, i)); end
      tick;
    end
    n_vec++; if (serial_valid !== 1'b0) begin n_err++; $display("FAIL midreset_end got=%b exp=0", serial_valid); end
  endtask

`ifdef SHIFTREGISTER_SERIALIZER_PARITY_EN
  task automatic test_parity(input logic [W-1:0] w, input logic [W:0] seq);
    logic [W:0] s;
    s = seq;
    load_valid = 1'b1; parallel_input = w; shift_enable = 1'b1;
    tick;
    load_valid = 1'b0;
    for (int i = 0; i <= W; i++) begin
      n_vec++; if (serial_output !== s[W-i] || serial_last !== (i == W))
        begin n_err++; $display("FAIL parity_%b_bit%0d got o=%b l=%b exp o=%b l=%b", w, i, serial_output, serial_last, s[W-i], i == W); end
      tick;
    end
  endtask
`endif

  initial begin
    test_reset;
    test_single_frame(4'b1011);
    test_back_to_back(4'b1100, 4'b0011);
    test_stall(4'b1001);
    test_reset_mid_frame(4'b1110, 4'b0110);
`ifdef SHIFTREGISTER_SERIALIZER_PARITY_EN
    test_parity(4'b0111, 5'b01111);
    test_parity(4'b0101, 5'b01010);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
